// File: rtl/da_dct_odd_mac.sv
// Bit-serial distributed-arithmetic MAC producing 0.5*X1/X3/X5/X7 of an 8-point DCT from the
// four butterfly differences, walking the latched inputs MSB-first against a per-row ROM.
module da_dct_odd_mac #(
   parameter int IN_W   = 16,
   parameter int COEF_W = 16,
   parameter bit ROUND  = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             row,
   input  logic signed [IN_W-1:0] d0,
   input  logic signed [IN_W-1:0] d1,
   input  logic signed [IN_W-1:0] d2,
   input  logic signed [IN_W-1:0] d3,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [IN_W+1:0] dout,
   output logic [1:0]             out_row,
   output logic                   busy
);

   localparam int COEF_FRAC = 14;
   // Partial sums of four taps reach ~2.56 in Q2.14, so ROM entries carry two guard bits.
   localparam int ROM_W = COEF_W + 2;
   localparam int ACC_W = IN_W + COEF_W + 2;
   localparam int IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [IDX_W-1:0]        MSB_IDX = IDX_W'(IN_W - 1);
   localparam logic signed [ACC_W-1:0] RND     = ROUND ? ACC_W'(2 ** COEF_FRAC) : '0;

   localparam logic signed [ROM_W-1:0] C1 = ROM_W'(16069);
   localparam logic signed [ROM_W-1:0] C3 = ROM_W'(13623);
   localparam logic signed [ROM_W-1:0] C5 = ROM_W'(9102);
   localparam logic signed [ROM_W-1:0] C7 = ROM_W'(3196);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state, state_nxt;
   logic [IN_W-1:0]         d_q [4];
   logic [1:0]              row_q;
   logic [IDX_W-1:0]        bit_idx;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_rnd;
   logic [3:0]              addr;
   logic signed [ROM_W-1:0] rom_val;
   logic signed [ACC_W-1:0] rom_ext;
   logic                    load, step, capture, drain;
   logic                    unused_acc_bits;

   function automatic logic signed [ROM_W-1:0] tap_coef(input logic [1:0] r, input logic [1:0] k);
      logic signed [ROM_W-1:0] c;
      unique case ({r, k})
         4'b00_00: c = C1;
         4'b00_01: c = C3;
         4'b00_10: c = C5;
         4'b00_11: c = C7;
         4'b01_00: c = C3;
         4'b01_01: c = -C7;
         4'b01_10: c = -C1;
         4'b01_11: c = -C5;
         4'b10_00: c = C5;
         4'b10_01: c = -C1;
         4'b10_10: c = C7;
         4'b10_11: c = C3;
         4'b11_00: c = C7;
         4'b11_01: c = -C5;
         4'b11_10: c = C3;
         4'b11_11: c = -C1;
      endcase
      return c;
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      addr = '0;
      for (int k = 0; k < 4; k++) addr[k] = d_q[k][bit_idx];
   end

   // Partial-sum ROM: entry[addr] is the sum of the selected row's taps whose address bit is set.
   always_comb begin
      rom_val = '0;
      for (int k = 0; k < 4; k++)
         if (addr[k]) rom_val = rom_val + tap_coef(row_q, 2'(k));
   end

   assign rom_ext = {{(ACC_W-ROM_W){rom_val[ROM_W-1]}}, rom_val};
   assign acc_rnd = acc + RND;
   assign unused_acc_bits = ^{acc_rnd[ACC_W-1:IN_W+COEF_FRAC+3], acc_rnd[COEF_FRAC:0]};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (in_valid)              state_nxt = RUN;
         RUN:  if (bit_idx == '0)         state_nxt = DONE;
         DONE: if (out_valid && out_ready) state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      busy     = (state != IDLE);
      load     = (state == IDLE) && in_valid;
      step     = (state == RUN);
      capture  = (state == DONE) && !out_valid;
      drain    = (state == DONE) && out_valid && out_ready;
   end

   // DONE spends its first cycle registering the aligned result, then holds it until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) d_q[k] <= '0;
         row_q     <= '0;
         bit_idx   <= '0;
         acc       <= '0;
         dout      <= '0;
         out_row   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (load) begin
            d_q[0]  <= d0;
            d_q[1]  <= d1;
            d_q[2]  <= d2;
            d_q[3]  <= d3;
            row_q   <= row;
            acc     <= '0;
            bit_idx <= MSB_IDX;
         end
         if (step) begin
            // The sign bit carries weight -2^(IN_W-1), hence the subtraction on the first step.
            if (bit_idx == MSB_IDX) acc <= -rom_ext;
            else                    acc <= (acc <<< 1) + rom_ext;
            bit_idx <= bit_idx - IDX_W'(1);
         end
         if (capture) begin
            dout      <= acc_rnd[IN_W+COEF_FRAC+2:COEF_FRAC+1];
            out_row   <= row_q;
            out_valid <= 1'b1;
         end
         if (drain) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_da_dct_odd_mac.sv
// Self-checking bench for da_dct_odd_mac: floor and round-half-up instances share stimulus,
// results are predicted by a direct multiply-accumulate reference and queued per transaction.
module tb_da_dct_odd_mac;

   localparam int IN_W = 16;

   localparam longint COEF_TAB [4][4] = '{
      '{16069, 13623,   9102,   3196},
      '{13623, -3196, -16069,  -9102},
      '{ 9102, -16069,  3196,  13623},
      '{ 3196, -9102,  13623, -16069}
   };

   typedef struct {
      logic [1:0] row;
      int         a0, a1, a2, a3;
      longint     ef;
      longint     er;
   } vec_t;

   typedef struct {
      logic [1:0] row;
      longint     ef;
      longint     er;
   } sb_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid, out_ready;
   logic [1:0]             row;
   logic signed [IN_W-1:0] d0, d1, d2, d3;
   logic                   in_ready_f, out_valid_f, busy_f;
   logic                   in_ready_r, out_valid_r, busy_r;
   logic signed [IN_W+1:0] dout_f, dout_r;
   logic [1:0]             out_row_f, out_row_r;

   int  checks   = 0;
   int  failures = 0;
   sb_t sb [$];
   vec_t vecs [8];

   always #5 clk = ~clk;

   da_dct_odd_mac #(.IN_W(IN_W), .COEF_W(16), .ROUND(1'b0)) u_dut_f (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f), .row(row),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .out_valid(out_valid_f), .out_ready(out_ready),
      .dout(dout_f), .out_row(out_row_f), .busy(busy_f));

   da_dct_odd_mac #(.IN_W(IN_W), .COEF_W(16), .ROUND(1'b1)) u_dut_r (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r), .row(row),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .out_valid(out_valid_r), .out_ready(out_ready),
      .dout(dout_r), .out_row(out_row_r), .busy(busy_r));

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint model(input logic [1:0] r, input int a0, a1, a2, a3, input bit rnd);
      longint s;
      s = COEF_TAB[r][0] * a0 + COEF_TAB[r][1] * a1 + COEF_TAB[r][2] * a2 + COEF_TAB[r][3] * a3;
      if (rnd) s = s + 16384;
      return s >>> 15;
   endfunction

   task automatic scramble();
      row = 2'($urandom);
      d0  = IN_W'($urandom);
      d1  = IN_W'($urandom);
      d2  = IN_W'($urandom);
      d3  = IN_W'($urandom);
   endtask

   // Called and returns at a falling edge; returns just after the accepting edge.
   task automatic send(input logic [1:0] r, input int a0, a1, a2, a3, input longint ef, er);
      int n = 0;
      while (!in_ready_f && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready_f) begin
         check("in_ready_timeout", 0, 1);
         return;
      end
      row = r;
      d0 = IN_W'(a0);
      d1 = IN_W'(a1);
      d2 = IN_W'(a2);
      d3 = IN_W'(a3);
      in_valid = 1'b1;
      @(posedge clk);
      sb.push_back('{row: r, ef: ef, er: er});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits for a result, optionally stalls and scrambles inputs, then checks and drains it.
   task automatic receive(input int hold, input bit toggle);
      sb_t e;
      int  n = 0;
      while (!out_valid_f && n < 100) begin
         if (toggle) begin
            check("in_ready_low_run", in_ready_f, 0);
            scramble();
            in_valid = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      if (!out_valid_f) begin
         check("out_valid_timeout", 0, 1);
         in_valid = 1'b0;
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         if (toggle) begin
            scramble();
            in_valid = 1'b1;
         end
         @(negedge clk);
         check("dout_hold", dout_f, e.ef);
         check("out_row_hold", out_row_f, e.row);
         check("in_ready_low_done", in_ready_f, 0);
      end
      in_valid = 1'b0;
      check("dout_floor", dout_f, e.ef);
      check("dout_round", dout_r, e.er);
      check("out_row", out_row_f, e.row);
      check("out_valid_pair", out_valid_r, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_after_release", in_ready_f, 1);
      check("out_valid_cleared", out_valid_f, 0);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{row: 2'd0, a0: 1000,   a1: 0,      a2: 0,      a3: 0,      ef: 490,    er: 490};
      vecs[1] = '{row: 2'd0, a0: -1000,  a1: 0,      a2: 0,      a3: 0,      ef: -491,   er: -490};
      vecs[2] = '{row: 2'd1, a0: 100,    a1: 100,    a2: 100,    a3: 100,    ef: -45,    er: -45};
      vecs[3] = '{row: 2'd0, a0: -32768, a1: -32768, a2: -32768, a3: -32768, ef: -41990, er: -41990};
      vecs[4] = '{row: 2'd0, a0: 32767,  a1: 32767,  a2: 32767,  a3: 32767,  ef: 41988,  er: 41989};
      vecs[5] = '{row: 2'd3, a0: 1,      a1: -1,     a2: 1,      a3: -1,     ef: 1,      er: 1};
      vecs[6] = '{row: 2'd2, a0: 0,      a1: 0,      a2: 0,      a3: 0,      ef: 0,      er: 0};
      vecs[7] = '{row: 2'd1, a0: -1,     a1: 0,      a2: 0,      a3: 0,      ef: -1,     er: 0};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      row = '0;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready_f, 1);
      check("rst_out_valid", out_valid_f, 0);
      check("rst_dout", dout_f, 0);
      check("rst_busy", busy_f, 0);
      check("rst_out_row", out_row_f, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Latency: accepted at edge T, out_valid low after T+16 and high after T+17.
      send(2'd0, 1000, 0, 0, 0, 490, 490);
      repeat (16) @(posedge clk);
      #1 check("latency_not_early", out_valid_f, 0);
      check("busy_run", busy_f, 1);
      @(posedge clk);
      #1 check("latency_valid", out_valid_f, 1);
      @(negedge clk);
      receive(0, 1'b0);

      foreach (vecs[i]) begin
         send(vecs[i].row, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].ef, vecs[i].er);
         receive(0, 1'b0);
      end

      // Back-pressure with inputs scrambled throughout RUN and DONE.
      send(2'd2, 1234, -567, 890, -12, model(2'd2, 1234, -567, 890, -12, 1'b0),
           model(2'd2, 1234, -567, 890, -12, 1'b1));
      receive(5, 1'b1);

      // Reset in the middle of RUN discards the partial result immediately.
      send(2'd0, 1000, 0, 0, 0, 490, 490);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid_f, 0);
      check("midrst_dout", dout_f, 0);
      check("midrst_dout_round", dout_r, 0);
      check("midrst_busy", busy_f, 0);
      check("midrst_in_ready", in_ready_f, 1);
      void'(sb.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(2'd3, 500, -200, 300, -100, model(2'd3, 500, -200, 300, -100, 1'b0),
           model(2'd3, 500, -200, 300, -100, 1'b1));
      receive(0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         send(2'(r), -32768, -32768, -32768, -32768, model(2'(r), -32768, -32768, -32768, -32768, 1'b0),
              model(2'(r), -32768, -32768, -32768, -32768, 1'b1));
         receive(0, 1'b0);
         send(2'(r), 32767, 32767, 32767, 32767, model(2'(r), 32767, 32767, 32767, 32767, 1'b0),
              model(2'(r), 32767, 32767, 32767, 32767, 1'b1));
         receive(0, 1'b0);
      end

      for (int i = 0; i < 2000; i++) begin
         logic [1:0] r;
         logic signed [IN_W-1:0] t0, t1, t2, t3;
         r  = 2'($urandom_range(0, 3));
         t0 = IN_W'($urandom);
         t1 = IN_W'($urandom);
         t2 = IN_W'($urandom);
         t3 = IN_W'($urandom);
         send(r, int'(t0), int'(t1), int'(t2), int'(t3),
              model(r, int'(t0), int'(t1), int'(t2), int'(t3), 1'b0),
              model(r, int'(t0), int'(t1), int'(t2), int'(t3), 1'b1));
         receive((i % 7 == 0) ? 2 : 0, 1'b0);
      end

      check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
